tinker_muldiv: RTL and testbench
================================

Name: tinker_muldiv

Overview:
- Parametrised iterative multiply/divide unit for the tinker core's execute stage.
- Replaces the single-cycle combinational mul/div in the ALU path with a one-bit-per-cycle engine.
- Uses a valid/ready handshake on both sides, so control can stall while an operation is in flight.
- Adds a high-half multiply, remainder, a divide-by-zero flag, a destination tag pass-through and an abort for flushing.

Parameters:
- WIDTH, 64: operand and result width in bits; must be 4 or more.
- TAG_W, 5: width of the destination-register tag carried alongside each operation.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- abort  input  1  synchronous flush; kills any in-flight or completed operation.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request this cycle.
- in_op  input  2  operation: 00 MUL (low half), 01 MULHU (unsigned high half), 10 DIVU (quotient), 11 REMU (remainder).
- in_a  input  WIDTH  multiplicand, or dividend.
- in_b  input  WIDTH  multiplier, or divisor.
- in_tag  input  TAG_W  destination tag, returned unchanged with the result.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_result  output  WIDTH  result selected by in_op.
- out_tag  output  TAG_W  tag captured at accept.
- out_dbz  output  1  set when a DIVU or REMU operation had in_b == 0.

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (reset == 0 at a clock edge):
  - State goes to IDLE; the step counter is cleared.
  - out_valid = 0, out_result = 0, out_tag = 0, out_dbz = 0.
  - in_ready is high in the first cycle after reset is released.
  - Reset has priority over abort and both handshakes, including mid-operation.
- in_ready is a combinational function of state, never of in_valid:
  - high in IDLE;
  - high in DONE only when out_ready is high;
  - otherwise low.
- Accept: in_valid and in_ready both high at a clock edge. The unit latches op, a, b and tag, clears the counter and enters BUSY.
- BUSY:
  - Exactly one algorithm step per clock edge; the counter increments each step.
  - After the WIDTH-th step the unit enters DONE.
  - out_valid is first high in the cycle following the edge of step WIDTH, so latency is fixed at WIDTH cycles from the accept edge, for every op and every operand value.
- Multiply:
  - Unsigned shift-add into a 2*WIDTH-bit product.
  - MUL returns product[WIDTH-1:0]; MULHU returns product[2*WIDTH-1:WIDTH].
  - All arithmetic is unsigned, modulo 2^WIDTH per half.
- Divide:
  - Restoring division, MSB first, with a (WIDTH+1)-bit partial remainder.
  - DIVU returns the quotient; REMU returns the remainder.
- Divide by zero (divisor 0):
  - No early exit; the algorithm naturally yields quotient all-ones and remainder equal to the dividend.
  - out_dbz = 1. For MUL and MULHU, out_dbz is always 0.
- DONE:
  - out_valid is held high; out_result, out_tag and out_dbz are held stable until out_valid and out_ready are both high at an edge.
  - On that edge, if in_valid is also high, the new request is accepted and the state goes directly to BUSY (back-to-back, no bubble). Otherwise the state goes to IDLE with out_valid = 0.
- Abort (reset inactive, abort = 1 at an edge):
  - State goes to IDLE and out_valid = 0.
  - Any in-flight or completed result is discarded.
  - No request is accepted on that edge, even if in_valid and in_ready are both high.
  - out_result and out_tag are not cleared.
- Inputs in_a, in_b, in_op and in_tag are ignored outside the accept edge. Changing them during BUSY has no effect.
- out_valid never asserts in IDLE or BUSY.

Test Plan:
- WIDTH=64. Reset low for 2 cycles, then high. Check in_ready=1, out_valid=0, out_result=0. Then MUL a=7, b=6, tag=3: out_valid rises exactly 64 cycles after accept with out_result=42, out_tag=3, out_dbz=0.
- MULHU a=b=0xFFFF_FFFF_FFFF_FFFF -> out_result=0xFFFF_FFFF_FFFF_FFFE. MUL with the same operands -> out_result=1.
- DIVU a=100, b=7 -> out_result=14; REMU with the same operands -> out_result=2. DIVU a=5, b=0 -> out_result=0xFFFF_FFFF_FFFF_FFFF, out_dbz=1; REMU a=5, b=0 -> out_result=5, out_dbz=1.
- Hold out_ready=0 for 10 cycles after DONE: out_valid and out_result stay stable and in_ready stays 0. Then assert out_ready and in_valid together: the result is consumed and the next op is accepted on the same edge; its out_valid appears 64 cycles later.
- Assert abort at step 20 of a DIVU: out_valid stays 0 and the next cycle shows in_ready=1. Assert reset=0 at step 30 of a second op: the next cycle shows IDLE and all outputs at reset values.
- WIDTH=8, TAG_W=2: MUL 200*3 -> out_result=0x58, MULHU -> out_result=0x02, DIVU 255/16 -> out_result=15, REMU -> out_result=15. Latency is 8 cycles for each.

Source files
------------

// File: rtl/tinker_muldiv.sv
// rtl/tinker_muldiv.sv - iterative one-bit-per-cycle unsigned multiply/divide unit
// Shift-add multiply and restoring divide share a fixed WIDTH-cycle latency.
module tinker_muldiv #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dbz
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [TAG_W-1:0]   tag_q;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   result_next;
  logic               accept;

  always_comb begin
    in_ready = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    // Multiplier sits in the low half and shifts out LSB first.
    mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]};
    if (prod[0]) mul_sum = mul_sum + {1'b0, a_q};
    prod_next = {mul_sum, prod[WIDTH-1:1]};

    // Dividend bits shift out of quo's MSB as quotient bits shift in.
    div_shift = {rem, quo[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, b_q};
    rem_next  = div_ge ? (div_shift[WIDTH-1:0] - b_q) : div_shift[WIDTH-1:0];
    quo_next  = {quo[WIDTH-2:0], div_ge};

    result_next = '0;
    case (op_q)
      2'b00:   result_next = prod_next[WIDTH-1:0];
      2'b01:   result_next = prod_next[2*WIDTH-1:WIDTH];
      2'b10:   result_next = quo_next;
      default: result_next = rem_next;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      out_dbz    <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        BUSY: begin
          prod <= prod_next;
          quo  <= quo_next;
          rem  <= rem_next;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            state      <= DONE;
            out_valid  <= 1'b1;
            out_result <= result_next;
            out_tag    <= tag_q;
            out_dbz    <= op_q[1] && (b_q == '0);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (accept) begin
        op_q  <= in_op;
        a_q   <= in_a;
        b_q   <= in_b;
        tag_q <= in_tag;
        prod  <= {{WIDTH{1'b0}}, in_b};
        quo   <= in_a;
        rem   <= '0;
        cnt   <= '0;
        state <= BUSY;
      end
    end
  end

endmodule

// File: tb/tb_tinker_muldiv.sv
// tb/tb_tinker_muldiv.sv - directed bench for tinker_muldiv at WIDTH=64 and WIDTH=8
module tb_tinker_muldiv;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic abort = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic        v64 = 0, rdy64, ov64, ordy64 = 0, dbz64;
  logic [1:0]  op64 = 0;
  logic [63:0] a64 = 0, b64 = 0, res64;
  logic [4:0]  tag64 = 0, otag64;

  logic        v8 = 0, rdy8, ov8, ordy8 = 0, dbz8;
  logic [1:0]  op8 = 0;
  logic [7:0]  a8 = 0, b8 = 0, res8;
  logic [1:0]  tag8 = 0, otag8;

  always #5 clk = ~clk;

  tinker_muldiv #(.WIDTH(64), .TAG_W(5)) dut64 (
    .clk(clk), .reset(reset), .abort(abort),
    .in_valid(v64), .in_ready(rdy64), .in_op(op64), .in_a(a64), .in_b(b64), .in_tag(tag64),
    .out_valid(ov64), .out_ready(ordy64), .out_result(res64), .out_tag(otag64), .out_dbz(dbz64)
  );

  tinker_muldiv #(.WIDTH(8), .TAG_W(2)) dut8 (
    .clk(clk), .reset(reset), .abort(abort),
    .in_valid(v8), .in_ready(rdy8), .in_op(op8), .in_a(a8), .in_b(b8), .in_tag(tag8),
    .out_valid(ov8), .out_ready(ordy8), .out_result(res8), .out_tag(otag8), .out_dbz(dbz8)
  );

  // Called #1 after a rising edge with in_ready high; scrambles inputs after accept.
  task automatic issue64(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] tag);
    v64 = 1; op64 = op; a64 = a; b64 = b; tag64 = tag;
    @(posedge clk); #1;
    v64 = 0; a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
    op64 = 2'($urandom); tag64 = 5'($urandom);
  endtask

  task automatic wait64(output int cyc);
    cyc = 0;
    while (cyc < 200 && ov64 !== 1'b1) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic consume64;
    ordy64 = 1;
    @(posedge clk); #1;
    ordy64 = 0;
  endtask

  task automatic issue8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] tag);
    v8 = 1; op8 = op; a8 = a; b8 = b; tag8 = tag;
    @(posedge clk); #1;
    v8 = 0; a8 = 8'($urandom); b8 = 8'($urandom); op8 = 2'($urandom); tag8 = 2'($urandom);
  endtask

  task automatic wait8(output int cyc);
    cyc = 0;
    while (cyc < 50 && ov8 !== 1'b1) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic test_reset;
    reset = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1;
    checks++; if (rdy64 !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", rdy64); end
    checks++; if (ov64 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", ov64); end
    checks++; if (res64 !== 64'd0) begin failures++; $display("FAIL reset_out_result got=%h exp=0", res64); end
    checks++; if (otag64 !== 5'd0 || dbz64 !== 1'b0) begin
      failures++; $display("FAIL reset_tag_dbz got=%h/%b exp=0/0", otag64, dbz64);
    end
    checks++; if (rdy8 !== 1'b1 || ov8 !== 1'b0) begin
      failures++; $display("FAIL reset8_ready_valid got=%b/%b exp=1/0", rdy8, ov8);
    end
  endtask

  task automatic test_ops64;
    logic [1:0]  ops[7];
    logic [63:0] as[7], bs[7], exps[7];
    logic        dz[7];
    logic [4:0]  tg[7];
    int c;
    ops[0] = 2'b00; as[0] = 64'd7;  bs[0] = 64'd6;  exps[0] = 64'd42; dz[0] = 0; tg[0] = 5'd3;
    ops[1] = 2'b01; as[1] = '1;     bs[1] = '1;     exps[1] = 64'hFFFF_FFFF_FFFF_FFFE; dz[1] = 0; tg[1] = 5'd17;
    ops[2] = 2'b00; as[2] = '1;     bs[2] = '1;     exps[2] = 64'd1;  dz[2] = 0; tg[2] = 5'd31;
    ops[3] = 2'b10; as[3] = 64'd100; bs[3] = 64'd7; exps[3] = 64'd14; dz[3] = 0; tg[3] = 5'd8;
    ops[4] = 2'b11; as[4] = 64'd100; bs[4] = 64'd7; exps[4] = 64'd2;  dz[4] = 0; tg[4] = 5'd9;
    ops[5] = 2'b10; as[5] = 64'd5;  bs[5] = 64'd0;  exps[5] = '1;     dz[5] = 1; tg[5] = 5'd10;
    ops[6] = 2'b11; as[6] = 64'd5;  bs[6] = 64'd0;  exps[6] = 64'd5;  dz[6] = 1; tg[6] = 5'd21;
    for (int i = 0; i < 7; i++) begin
      issue64(ops[i], as[i], bs[i], tg[i]);
      wait64(c);
      checks++; if (c != 64) begin failures++; $display("FAIL ops64_latency[%0d] got=%0d exp=64", i, c); end
      checks++; if (res64 !== exps[i]) begin failures++; $display("FAIL ops64_result[%0d] got=%h exp=%h", i, res64, exps[i]); end
      checks++; if (dbz64 !== dz[i]) begin failures++; $display("FAIL ops64_dbz[%0d] got=%b exp=%b", i, dbz64, dz[i]); end
      checks++; if (otag64 !== tg[i]) begin failures++; $display("FAIL ops64_tag[%0d] got=%0d exp=%0d", i, otag64, tg[i]); end
      consume64;
      checks++; if (ov64 !== 1'b0 || rdy64 !== 1'b1) begin
        failures++; $display("FAIL ops64_consume[%0d] got=%b/%b exp=0/1", i, ov64, rdy64);
      end
    end
  endtask

  task automatic test_back_to_back;
    int c;
    issue64(2'b10, 64'd100, 64'd7, 5'd9);
    wait64(c);
    checks++; if (c != 64) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=64", c); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++; if (ov64 !== 1'b1 || res64 !== 64'd14 || rdy64 !== 1'b0 || otag64 !== 5'd9) begin
        failures++; $display("FAIL stall_hold[%0d] got=%b/%h/%b/%0d exp=1/e/0/9", i, ov64, res64, rdy64, otag64);
      end
    end
    ordy64 = 1; v64 = 1; op64 = 2'b00; a64 = 64'd3; b64 = 64'd5; tag64 = 5'd4;
    #1;
    checks++; if (rdy64 !== 1'b1) begin failures++; $display("FAIL b2b_in_ready got=%b exp=1", rdy64); end
    @(posedge clk); #1;
    ordy64 = 0; v64 = 0; a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
    checks++; if (ov64 !== 1'b0 || rdy64 !== 1'b0) begin
      failures++; $display("FAIL b2b_busy got=%b/%b exp=0/0", ov64, rdy64);
    end
    wait64(c);
    checks++; if (c != 64) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=64", c); end
    checks++; if (res64 !== 64'd15 || otag64 !== 5'd4) begin
      failures++; $display("FAIL b2b_second_result got=%h/%0d exp=f/4", res64, otag64);
    end
    consume64;
  endtask

  task automatic test_abort;
    int hits;
    issue64(2'b10, 64'd100, 64'd7, 5'd6);
    repeat (19) @(posedge clk);
    #1 abort = 1;
    @(posedge clk); #1;
    abort = 0;
    checks++; if (ov64 !== 1'b0 || rdy64 !== 1'b1) begin
      failures++; $display("FAIL abort_idle got=%b/%b exp=0/1", ov64, rdy64);
    end
    checks++; if (res64 !== 64'd15 || otag64 !== 5'd4) begin
      failures++; $display("FAIL abort_keeps_outputs got=%h/%0d exp=f/4", res64, otag64);
    end
    v64 = 1; op64 = 2'b00; a64 = 64'd2; b64 = 64'd2; tag64 = 5'd1; abort = 1;
    @(posedge clk); #1;
    abort = 0; v64 = 0;
    checks++; if (rdy64 !== 1'b1) begin failures++; $display("FAIL abort_blocks_accept got=%b exp=1", rdy64); end
    hits = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (ov64 !== 1'b0) hits++;
    end
    checks++; if (hits != 0) begin failures++; $display("FAIL abort_no_result got=%0d exp=0", hits); end
  endtask

  task automatic test_reset_mid;
    issue64(2'b00, 64'd7, 64'd6, 5'd2);
    repeat (29) @(posedge clk);
    #1 reset = 0;
    @(posedge clk); #1;
    checks++; if (rdy64 !== 1'b1 || ov64 !== 1'b0) begin
      failures++; $display("FAIL reset_mid_state got=%b/%b exp=1/0", rdy64, ov64);
    end
    checks++; if (res64 !== 64'd0 || otag64 !== 5'd0 || dbz64 !== 1'b0) begin
      failures++; $display("FAIL reset_mid_outputs got=%h/%0d/%b exp=0/0/0", res64, otag64, dbz64);
    end
    reset = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_width8;
    logic [1:0] ops[4];
    logic [7:0] exps[4];
    int c;
    ops[0] = 2'b00; exps[0] = 8'h58;
    ops[1] = 2'b01; exps[1] = 8'h02;
    ops[2] = 2'b10; exps[2] = 8'd15;
    ops[3] = 2'b11; exps[3] = 8'd15;
    for (int i = 0; i < 4; i++) begin
      if (i < 2) issue8(ops[i], 8'd200, 8'd3, 2'(i + 1));
      else       issue8(ops[i], 8'd255, 8'd16, 2'(i + 1));
      wait8(c);
      checks++; if (c != 8) begin failures++; $display("FAIL w8_latency[%0d] got=%0d exp=8", i, c); end
      checks++; if (res8 !== exps[i] || otag8 !== 2'(i + 1) || dbz8 !== 1'b0) begin
        failures++; $display("FAIL w8_result[%0d] got=%h/%0d/%b exp=%h/%0d/0", i, res8, otag8, dbz8, exps[i], i + 1);
      end
      ordy8 = 1;
      @(posedge clk); #1;
      ordy8 = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_ops64;
    test_back_to_back;
    test_abort;
    test_reset_mid;
    test_width8;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
